delay_line_ctrl: RTL and testbench

Sequencer for a RAM-based fixed-length delay line (LEN entries). It owns the line's clock enable and adds valid/ready handshakes on both sides. It tracks fill level, suppresses stale output until the line is primed, and drains the line on a flush command by pushing zeros. It sits between an upstream sample producer and a downstream consumer, such as a decimation filter stage or an FFT buffer.

---
 rtl/delay_line_ctrl.sv | 150 +++++++++++++++
 tb/tb_delay_line_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// Sequencer for a RAM-based LEN-entry delay line: fill tracking, valid/ready on both sides, zero-push flush.
// Optional `define DELAY_LINE_CTRL_PRIME_EN pre-loads the line with LEN-1 zeros after reset.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 25,
    parameter int LEN        = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  sr_ce,
    output logic [DATA_WIDTH-1:0] sr_di,
    input  logic [DATA_WIDTH-1:0] sr_do
);

    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(LEN - 1);

`ifdef DELAY_LINE_CTRL_PRIME_EN
    typedef enum logic [1:0] {FILL, RUN, FLUSH, PRIME} state_t;
    localparam state_t START_STATE = PRIME;
`else
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    localparam state_t START_STATE = FILL;
`endif

    state_t                  state_reg, state_next;
    logic [CW-1:0]           fill_cnt_reg, fill_cnt_next;
    logic [CW-1:0]           drain_cnt_reg, drain_cnt_next;
    logic                    pending_reg;
    logic                    out_valid_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic                    flush_done_reg, flush_done_next;
    logic                    active_reg;
    logic                    free;
    logic                    push_in;
    logic                    emit;
    logic                    capture;

    // active_reg keeps every combinational output low while reset is held
    assign free     = !out_valid_reg || out_ready;
    assign in_ready = active_reg && free && (state_reg == FILL || state_reg == RUN);
    assign push_in  = in_valid && in_ready;
    assign capture  = pending_reg && free;

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign flush_done = flush_done_reg;

    always_comb begin
        state_next      = state_reg;
        fill_cnt_next   = fill_cnt_reg;
        drain_cnt_next  = drain_cnt_reg;
        flush_done_next = 1'b0;
        sr_ce           = 1'b0;
        sr_di           = '0;
        emit            = 1'b0;
        case (state_reg)
            FILL: begin
                if (push_in) begin
                    sr_ce         = 1'b1;
                    sr_di         = in_data;
                    fill_cnt_next = fill_cnt_reg + CW'(1);
                    if (fill_cnt_reg == CNT_MAX - CW'(1))
                        state_next = RUN;
                end
                if (flush) begin
                    if (push_in || fill_cnt_reg != '0) begin
                        state_next     = FLUSH;
                        drain_cnt_next = CNT_MAX;
                    end else begin
                        flush_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (push_in) begin
                    sr_ce = 1'b1;
                    sr_di = in_data;
                    emit  = 1'b1;
                end
                if (flush) begin
                    state_next     = FLUSH;
                    drain_cnt_next = CNT_MAX;
                end
            end
            FLUSH: begin
                // Always LEN-1 zero pushes; only the last fill_cnt of them carry real samples out.
                if (free) begin
                    sr_ce          = 1'b1;
                    emit           = (drain_cnt_reg <= fill_cnt_reg);
                    drain_cnt_next = drain_cnt_reg - CW'(1);
                    if (drain_cnt_reg <= fill_cnt_reg)
                        fill_cnt_next = fill_cnt_reg - CW'(1);
                    if (drain_cnt_reg == CW'(1)) begin
                        state_next      = FILL;
                        flush_done_next = 1'b1;
                    end
                end
            end
`ifdef DELAY_LINE_CTRL_PRIME_EN
            PRIME: begin
                if (active_reg) begin
                    sr_ce          = 1'b1;
                    drain_cnt_next = drain_cnt_reg - CW'(1);
                    if (drain_cnt_reg == CW'(1)) begin
                        state_next    = RUN;
                        fill_cnt_next = CNT_MAX;
                    end
                end
            end
`endif
            default: state_next = START_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= START_STATE;
            fill_cnt_reg   <= '0;
            drain_cnt_reg  <= CNT_MAX;
            pending_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            flush_done_reg <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fill_cnt_reg   <= fill_cnt_next;
            drain_cnt_reg  <= drain_cnt_next;
            flush_done_reg <= flush_done_next;
            active_reg     <= 1'b1;
            // A held capture is safe: no push can occur until the output register frees up, so sr_do is stable.
            pending_reg    <= emit || (pending_reg && !free);
            if (capture) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sr_do;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomised self-checking bench for delay_line_ctrl with a behavioural delay-line and sample-queue model.
// Honours DELAY_LINE_CTRL_PRIME_EN when defined.
module tb_delay_line_ctrl;
    localparam int DW  = 16;
    localparam int LEN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          sr_ce;
    logic [DW-1:0] sr_di;
    logic [DW-1:0] sr_do;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_line_ctrl #(.DATA_WIDTH(DW), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .flush_done(flush_done),
        .sr_ce(sr_ce), .sr_di(sr_di), .sr_do(sr_do)
    );

    // Delay line: circular store of LEN-1 entries with registered read
    logic [DW-1:0] mem [0:LEN-2];
    int wp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN - 1; i++) mem[i] <= '0;
            wp    <= 0;
            sr_do <= '0;
        end else if (sr_ce) begin
            sr_do   <= mem[wp];
            mem[wp] <= sr_di;
            wp      <= (wp == LEN - 2) ? 0 : wp + 1;
        end
    end

    // Reference: real samples held in the line; outputs appear once the line is full or on flush
    logic [DW-1:0] line_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int flush_busy = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (flush_done) begin
                done_cnt++;
                flush_busy = 0;
            end
            if (in_valid && in_ready) begin
                if (line_q.size() == LEN - 1) exp_q.push_back(line_q.pop_front());
                line_q.push_back(in_data);
            end
            if (flush && !flush_busy) begin
                while (line_q.size() > 0) exp_q.push_back(line_q.pop_front());
                flush_busy = 1;
            end
            if (out_valid && out_ready) begin
                obs_q.push_back(out_data);
                $display("[%0d] out_data=%0d", cyc, out_data);
            end
        end
    end

    task automatic model_clear();
        line_q.delete();
        exp_q.delete();
        obs_q.delete();
        flush_busy = 0;
`ifdef DELAY_LINE_CTRL_PRIME_EN
        for (int i = 0; i < LEN - 1; i++) line_q.push_back('0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (LEN + 3) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data %0d not accepted in 50 cycles", d);
        end
    endtask

    task automatic settle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = DW'($urandom_range(1, 1000));
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== '0)     begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        if (sr_ce !== 1'b0)      begin errors++; $display("FAIL reset_sr_ce: got %b want 0", sr_ce); end
        if (sr_di !== '0)        begin errors++; $display("FAIL reset_sr_di: got %0d want 0", sr_di); end
        do_reset();
    endtask

    task automatic test_fill_run();
        int t0;
        t0 = cyc;
        for (int v = 1; v <= 6; v++) send(DW'(v));
        checks++;
        if (cyc - t0 !== 6) begin errors++; $display("FAIL fill_run_throughput: took %0d cycles want 6", cyc - t0); end
        settle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL fill_run_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_run_data[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [DW-1:0] held;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(100);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) in_data = in_data + 1'b1;
        end
        @(negedge clk);
        held = out_data;
        for (int s = 0; s < 5; s++) begin
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            if (out_data !== held)  begin errors++; $display("FAIL bp_out_data_stable: got %0d want %0d", out_data, held); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) in_data = in_data + 1'b1;
        end
        settle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush(input int n_first, input int base);
        int d0;
        d0 = done_cnt;
        for (int v = 0; v < n_first; v++) send(DW'(base + 10 * v));
        in_valid = 1'b0;
        pulse_flush();
        for (int k = 0; k < 4 * LEN + 10 && flush_busy; k++) @(posedge clk);
        #1;
        checks += 2;
        if (flush_busy) begin errors++; $display("FAIL flush_timeout: flush_done not seen (base %0d)", base); end
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL flush_done_pulses: got %0d want 1", done_cnt - d0); end
        // After draining the controller is back in FILL: LEN-1 fresh inputs must yield nothing
        for (int v = 0; v < LEN - 1; v++) send(DW'(base + 500 + v));
        settle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL flush_count: got %0d outputs want %0d (base %0d)", obs_q.size(), exp_q.size(), base);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_data[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
            end
        end
        obs_q.delete(); exp_q.delete();
        pulse_flush();
        settle(4 * LEN + 4);
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush_empty();
        int d0;
        d0 = done_cnt;
        pulse_flush();
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_empty_done: got %b want 1", flush_done); end
        settle(2);
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL flush_empty_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = (!flush_busy && !flush && $urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4 * LEN + 10 && flush_busy; k++) @(posedge clk);
        settle(8);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_flush();
        int d0;
        for (int v = 0; v < LEN + 1; v++) send(DW'(300 + v));
        in_valid = 1'b0;
        pulse_flush();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        if (out_data !== '0)     begin errors++; $display("FAIL midrst_out_data: got %0d want 0", out_data); end
        if (flush_done !== 1'b0) begin errors++; $display("FAIL midrst_flush_done: got %b want 0", flush_done); end
        if (sr_ce !== 1'b0)      begin errors++; $display("FAIL midrst_sr_ce: got %b want 0", sr_ce); end
        if (in_ready !== 1'b0)   begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        d0 = done_cnt;
        do_reset();
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
        test_fill_run();
    endtask

`ifdef DELAY_LINE_CTRL_PRIME_EN
    task automatic test_prime();
        int n_ce;
        n_ce = 0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < LEN + 3; c++) begin
            @(negedge clk);
            if (sr_ce) begin
                n_ce++;
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL prime_in_ready: got %b want 0", in_ready); end
            end
        end
        checks++;
        if (n_ce !== LEN - 1) begin errors++; $display("FAIL prime_pushes: got %0d want %0d", n_ce, LEN - 1); end
        @(posedge clk); #1;
        send(DW'(5));
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL prime_first_valid: got %b want 1", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL prime_first_data: got %0d want 0", out_data); end
        settle(4);
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_fill_run();
        test_backpressure();
        test_flush(5, 10);
        test_flush(2, 7);
        test_flush_empty();
        test_random();
        test_reset_mid_flush();
`ifdef DELAY_LINE_CTRL_PRIME_EN
        test_prime();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
